// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32I decoder feeding a STAGES-deep control-word pipeline.
// Built-in load-use bubble, stall hold and flush of stage 0.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready instruction handshake (instr accepted when both high)
//   instr             raw RV32I instruction word
//   stall             downstream hold, freezes every stage register
//   flush             redirect, kills stage 0 and the incoming instruction
//   stage_valid       bit k set when stage k holds a live instruction
//   stage_ctrl        stage k control word at [k*CW_W +: CW_W]
//   illegal           registered one-cycle pulse for an accepted bad opcode
//
// Build option: define CTRL_MULDIV_EN to decode the M extension
// (op_reg with funct7=0000001); otherwise those encodings are illegal.

package ctrl_pipe_pkg;

  localparam logic [6:0] op_lui   = 7'b0110111;
  localparam logic [6:0] op_auipc = 7'b0010111;
  localparam logic [6:0] op_jal   = 7'b1101111;
  localparam logic [6:0] op_jalr  = 7'b1100111;
  localparam logic [6:0] op_br    = 7'b1100011;
  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;

  // aluop: low three bits follow funct3, sub/sra get their own codes
  localparam logic [3:0] alu_add = 4'h0;
  localparam logic [3:0] alu_sub = 4'h8;
  localparam logic [3:0] alu_sra = 4'hd;

  localparam logic am1_rs1 = 1'b0;
  localparam logic am1_pc  = 1'b1;

  localparam logic [2:0] am2_i_imm = 3'd0;
  localparam logic [2:0] am2_u_imm = 3'd1;
  localparam logic [2:0] am2_b_imm = 3'd2;
  localparam logic [2:0] am2_s_imm = 3'd3;
  localparam logic [2:0] am2_j_imm = 3'd4;
  localparam logic [2:0] am2_rs2   = 3'd5;

  localparam logic [3:0] rfm_alu_out  = 4'd0;
  localparam logic [3:0] rfm_u_imm    = 4'd2;
  localparam logic [3:0] rfm_lw       = 4'd3;
  localparam logic [3:0] rfm_pc_plus4 = 4'd4;
  localparam logic [3:0] rfm_lb       = 4'd5;
  localparam logic [3:0] rfm_lbu      = 4'd6;
  localparam logic [3:0] rfm_lh       = 4'd7;
  localparam logic [3:0] rfm_lhu      = 4'd8;

  localparam logic [1:0] pcm_alu_out  = 2'd1;
  localparam logic [1:0] pcm_alu_mod2 = 2'd2;

  localparam logic cmpm_rs2 = 1'b0;

  typedef struct packed {
    logic [6:0] opcode;
    logic [3:0] aluop;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic [3:0] regfilemux_sel;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] pcmux_sel;
    logic       cmpmux_sel;
    logic [2:0] cmp_op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic       muldiv;
  } rv32i_control_word;

endpackage

module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int CW_W   = $bits(rv32i_control_word)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr,
  input  logic                   stall,
  input  logic                   flush,
  output logic [STAGES-1:0]      stage_valid,
  output logic [STAGES*CW_W-1:0] stage_ctrl,
  output logic                   illegal
);

  logic [6:0]        w_op;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [3:0]        w_rfm_ld;
  rv32i_control_word w_dec;
  logic              w_legal;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_hit1;
  logic              w_hit2;
  logic              w_hazard;
  logic              w_accept;

  logic              r_rdy;
  logic              r_illegal;
  logic [4:0]        r_ld_rd;
  logic [STAGES-1:0] r_valid;
  logic [CW_W-1:0]   r_ctrl [STAGES];

  assign w_op = instr[6:0];
  assign w_f3 = instr[14:12];
  assign w_f7 = instr[31:25];

  always_comb begin
    w_rfm_ld = rfm_lw;
    case (w_f3)
      3'b000:  w_rfm_ld = rfm_lb;
      3'b001:  w_rfm_ld = rfm_lh;
      3'b100:  w_rfm_ld = rfm_lbu;
      3'b101:  w_rfm_ld = rfm_lhu;
      default: w_rfm_ld = rfm_lw;
    endcase
  end

  always_comb begin
    w_dec        = '0;
    w_legal      = 1'b1;
    w_use_rs1    = 1'b0;
    w_use_rs2    = 1'b0;
    w_dec.opcode = w_op;
    w_dec.rd     = instr[11:7];
    w_dec.rs1    = instr[19:15];
    w_dec.rs2    = instr[24:20];
    w_dec.funct3 = w_f3;
    w_dec.aluop  = alu_add;
    unique case (1'b1)
      w_op == op_lui: begin
        w_dec.regfilemux_sel = rfm_u_imm;
        w_dec.load_regfile   = 1'b1;
      end
      w_op == op_auipc: begin
        w_dec.alumux1_sel    = am1_pc;
        w_dec.alumux2_sel    = am2_u_imm;
        w_dec.regfilemux_sel = rfm_alu_out;
        w_dec.load_regfile   = 1'b1;
      end
      w_op == op_jal: begin
        w_dec.alumux1_sel    = am1_pc;
        w_dec.alumux2_sel    = am2_j_imm;
        w_dec.regfilemux_sel = rfm_pc_plus4;
        w_dec.load_regfile   = 1'b1;
        w_dec.pcmux_sel      = pcm_alu_out;
      end
      w_op == op_jalr: begin
        // target LSB is cleared downstream
        w_dec.alumux1_sel    = am1_rs1;
        w_dec.alumux2_sel    = am2_i_imm;
        w_dec.regfilemux_sel = rfm_pc_plus4;
        w_dec.load_regfile   = 1'b1;
        w_dec.pcmux_sel      = pcm_alu_mod2;
        w_use_rs1            = 1'b1;
      end
      w_op == op_br: begin
        w_dec.alumux1_sel = am1_pc;
        w_dec.alumux2_sel = am2_b_imm;
        w_dec.cmpmux_sel  = cmpm_rs2;
        w_dec.cmp_op      = w_f3;
        w_use_rs1         = 1'b1;
        w_use_rs2         = 1'b1;
      end
      w_op == op_load: begin
        w_dec.alumux1_sel    = am1_rs1;
        w_dec.alumux2_sel    = am2_i_imm;
        w_dec.regfilemux_sel = w_rfm_ld;
        w_dec.load_regfile   = 1'b1;
        w_dec.mem_read       = 1'b1;
        w_use_rs1            = 1'b1;
      end
      w_op == op_store: begin
        w_dec.alumux1_sel = am1_rs1;
        w_dec.alumux2_sel = am2_s_imm;
        w_dec.mem_write   = 1'b1;
        w_use_rs1         = 1'b1;
        w_use_rs2         = 1'b1;
      end
      w_op == op_imm: begin
        w_dec.alumux1_sel    = am1_rs1;
        w_dec.alumux2_sel    = am2_i_imm;
        w_dec.regfilemux_sel = rfm_alu_out;
        w_dec.load_regfile   = 1'b1;
        w_use_rs1            = 1'b1;
        // instr[30] is an immediate bit except for shifts
        if (w_f3 == 3'b101 && w_f7[5])
          w_dec.aluop = alu_sra;
        else
          w_dec.aluop = {1'b0, w_f3};
      end
      w_op == op_reg: begin
        w_dec.alumux1_sel    = am1_rs1;
        w_dec.alumux2_sel    = am2_rs2;
        w_dec.regfilemux_sel = rfm_alu_out;
        w_dec.load_regfile   = 1'b1;
        w_use_rs1            = 1'b1;
        w_use_rs2            = 1'b1;
        if (w_f7 == 7'b0000001) begin
`ifdef CTRL_MULDIV_EN
          w_dec.muldiv = 1'b1;
          w_dec.aluop  = {1'b0, w_f3};
`else
          w_legal = 1'b0;
`endif
        end else if (w_f3 == 3'b000 && w_f7[5]) begin
          w_dec.aluop = alu_sub;
        end else if (w_f3 == 3'b101 && w_f7[5]) begin
          w_dec.aluop = alu_sra;
        end else begin
          w_dec.aluop = {1'b0, w_f3};
        end
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_dec     = '0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
    end
    if (w_dec.rd == 5'd0)
      w_dec.load_regfile = 1'b0;
  end

  // r_ld_rd is nonzero only while stage 0 holds a live load with rd!=0
  assign w_hit1   = w_use_rs1 && (instr[19:15] == r_ld_rd);
  assign w_hit2   = w_use_rs2 && (instr[24:20] == r_ld_rd);
  assign w_hazard = in_valid && (r_ld_rd != 5'd0) && (w_hit1 || w_hit2);

  // a flush drops the incoming word, so the hazard no longer matters
  assign in_ready = r_rdy && !stall && (flush || !w_hazard);
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy     <= 1'b0;
      r_illegal <= 1'b0;
      r_ld_rd   <= '0;
      r_valid   <= '0;
      for (int k = 0; k < STAGES; k++)
        r_ctrl[k] <= '0;
    end else begin
      r_rdy     <= 1'b1;
      r_illegal <= w_accept && !w_legal;
      if (!stall) begin
        for (int k = STAGES - 1; k > 0; k--) begin
          r_valid[k] <= r_valid[k-1];
          r_ctrl[k]  <= r_ctrl[k-1];
        end
      end
      // flush wins over stall for stage 0 only
      if (flush) begin
        r_valid[0] <= 1'b0;
        r_ctrl[0]  <= '0;
        r_ld_rd    <= '0;
      end else if (!stall) begin
        if (w_accept && w_legal) begin
          r_valid[0] <= 1'b1;
          r_ctrl[0]  <= w_dec;
          r_ld_rd    <= w_dec.mem_read ? w_dec.rd : 5'd0;
        end else begin
          r_valid[0] <= 1'b0;
          r_ctrl[0]  <= '0;
          r_ld_rd    <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_out
    assign stage_ctrl[g*CW_W +: CW_W] = r_ctrl[g];
  end

  assign stage_valid = r_valid;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed steps with a reference model and scoreboard
// queue for the ctrl_pipe decoder/control pipeline.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  localparam int NS = 3;
  localparam int CW = $bits(rv32i_control_word);

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] ADD   = 32'h002101B3;
  localparam logic [31:0] SUB   = 32'h40208233;
  localparam logic [31:0] SRA   = 32'h407352B3;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] BAD   = 32'h0000007F;
  localparam logic [31:0] MUL   = 32'h027302B3;
  localparam logic [31:0] JAL   = 32'h008000EF;
  localparam logic [31:0] JALR0 = 32'h00008067;
  localparam logic [31:0] LUI   = 32'h123453B7;
  localparam logic [31:0] AUIPC = 32'h00001417;
  localparam logic [31:0] SW    = 32'h0020A223;
  localparam logic [31:0] SRAI  = 32'h4034D493;
  localparam logic [31:0] ADDIN = 32'hFFF08093;
  localparam logic [31:0] LW4   = 32'h0000A203;
  localparam logic [31:0] ADDI4 = 32'h00400293;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] ADD00 = 32'h000001B3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic [31:0] instr = '0;
  logic in_ready;
  logic illegal;
  logic [NS-1:0] stage_valid;
  logic [NS*CW-1:0] stage_ctrl;

  int checks = 0;
  int errors = 0;

  ctrl_pipe #(.STAGES(NS), .CW_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr(instr),
    .stall(stall),
    .flush(flush),
    .stage_valid(stage_valid),
    .stage_ctrl(stage_ctrl),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic [NS-1:0] v;
    logic [NS*CW-1:0] c;
    logic ill;
  } exp_t;

  exp_t sbq[$];
  logic m_rdy;
  logic [NS-1:0] m_v;
  rv32i_control_word m_c [NS];

  task automatic check(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] i,
                                  output rv32i_control_word w,
                                  output logic ok, output logic u1,
                                  output logic u2);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    w = '0;
    ok = 1'b1;
    u1 = 1'b0;
    u2 = 1'b0;
    case (op)
      op_lui: begin
        w.regfilemux_sel = rfm_u_imm; w.load_regfile = 1'b1;
      end
      op_auipc: begin
        w.alumux1_sel = am1_pc; w.alumux2_sel = am2_u_imm;
        w.regfilemux_sel = rfm_alu_out; w.load_regfile = 1'b1;
      end
      op_jal: begin
        w.alumux1_sel = am1_pc; w.alumux2_sel = am2_j_imm;
        w.regfilemux_sel = rfm_pc_plus4; w.load_regfile = 1'b1;
        w.pcmux_sel = pcm_alu_out;
      end
      op_jalr: begin
        w.alumux2_sel = am2_i_imm; w.regfilemux_sel = rfm_pc_plus4;
        w.load_regfile = 1'b1; w.pcmux_sel = pcm_alu_mod2; u1 = 1'b1;
      end
      op_br: begin
        w.alumux1_sel = am1_pc; w.alumux2_sel = am2_b_imm;
        w.cmp_op = f3; u1 = 1'b1; u2 = 1'b1;
      end
      op_load: begin
        w.alumux2_sel = am2_i_imm; w.mem_read = 1'b1;
        w.load_regfile = 1'b1;
        w.regfilemux_sel = (f3 == 3'b000) ? rfm_lb :
                           (f3 == 3'b001) ? rfm_lh :
                           (f3 == 3'b100) ? rfm_lbu :
                           (f3 == 3'b101) ? rfm_lhu : rfm_lw;
        u1 = 1'b1;
      end
      op_store: begin
        w.alumux2_sel = am2_s_imm; w.mem_write = 1'b1;
        u1 = 1'b1; u2 = 1'b1;
      end
      op_imm: begin
        w.alumux2_sel = am2_i_imm; w.regfilemux_sel = rfm_alu_out;
        w.load_regfile = 1'b1; u1 = 1'b1;
        w.aluop = (f3 == 3'b101 && i[30]) ? alu_sra : {1'b0, f3};
      end
      op_reg: begin
        w.alumux2_sel = am2_rs2; w.regfilemux_sel = rfm_alu_out;
        w.load_regfile = 1'b1; u1 = 1'b1; u2 = 1'b1;
        if (i[31:25] == 7'b0000001) begin
`ifdef CTRL_MULDIV_EN
          w.muldiv = 1'b1; w.aluop = {1'b0, f3};
`else
          ok = 1'b0;
`endif
        end else if (f3 == 3'b000 && i[30]) w.aluop = alu_sub;
        else if (f3 == 3'b101 && i[30]) w.aluop = alu_sra;
        else w.aluop = {1'b0, f3};
      end
      default: ok = 1'b0;
    endcase
    if (ok) begin
      w.opcode = op;
      w.rd = i[11:7];
      w.rs1 = i[19:15];
      w.rs2 = i[24:20];
      w.funct3 = f3;
      if (w.rd == 5'd0) w.load_regfile = 1'b0;
    end else begin
      w = '0; u1 = 1'b0; u2 = 1'b0;
    end
  endfunction

  task automatic pop_cmp();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sbq observed=empty expected=entry");
      return;
    end
    e = sbq.pop_front();
    check({e.tag, ".valid"}, 192'(stage_valid), 192'(e.v));
    check({e.tag, ".ctrl"}, 192'(stage_ctrl), 192'(e.c));
    check({e.tag, ".ill"}, 192'(illegal), 192'(e.ill));
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic step(input string tag, input logic v,
                      input logic [31:0] ins, input logic st,
                      input logic fl);
    rv32i_control_word d;
    rv32i_control_word n [NS];
    logic [NS-1:0] nv;
    logic ok, u1, u2, haz, rdy, acc;
    exp_t e;
    in_valid = v;
    instr = ins;
    stall = st;
    flush = fl;
    #1;
    ref_dec(ins, d, ok, u1, u2);
    haz = v && m_v[0] && m_c[0].mem_read && (m_c[0].rd != 5'd0) &&
          ((u1 && ins[19:15] == m_c[0].rd) ||
           (u2 && ins[24:20] == m_c[0].rd));
    rdy = m_rdy && !st && (fl || !haz);
    check({tag, ".rdy"}, 192'(in_ready), 192'(rdy));
    acc = v && rdy && !fl;
    nv = m_v;
    n = m_c;
    if (!st) begin
      for (int k = NS - 1; k > 0; k--) begin
        nv[k] = m_v[k-1];
        n[k] = m_c[k-1];
      end
    end
    if (fl) begin
      nv[0] = 1'b0;
      n[0] = '0;
    end else if (!st) begin
      nv[0] = acc && ok;
      n[0] = (acc && ok) ? d : '0;
    end
    e.tag = tag;
    e.v = nv;
    e.c = {n[2], n[1], n[0]};
    e.ill = acc && !ok;
    sbq.push_back(e);
    m_v = nv;
    m_c = n;
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    pop_cmp();
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic model_clear();
    m_rdy = 1'b0;
    m_v = '0;
    for (int k = 0; k < NS; k++) m_c[k] = '0;
  endtask

  initial begin
    rv32i_control_word t;
    model_clear();
    rst_n = 1'b0;
    #6;
    check("rst.rdy", 192'(in_ready), 192'(0));
    check("rst.valid", 192'(stage_valid), 192'(0));
    check("rst.ctrl", 192'(stage_ctrl), 192'(0));
    check("rst.ill", 192'(illegal), 192'(0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel.rdy0", 192'(in_ready), 192'(0));
    @(posedge clk);
    #1;
    check("rel.rdy1", 192'(in_ready), 192'(1));
    m_rdy = 1'b1;
    @(negedge clk);

    step("addi", 1'b1, ADDI, 1'b0, 1'b0);
    t = stage_ctrl[CW-1:0];
    check("addi.lr", 192'(t.load_regfile), 192'(1));
    check("addi.aluop", 192'(t.aluop), 192'(alu_add));
    idle("addi.c2");
    idle("addi.c3");
    check("addi.v100", 192'(stage_valid), 192'(3'b100));

    step("lw", 1'b1, LW, 1'b0, 1'b0);
    step("add.hz", 1'b1, ADD, 1'b0, 1'b0);
    step("add.go", 1'b1, ADD, 1'b0, 1'b0);
    step("sub", 1'b1, SUB, 1'b0, 1'b0);
    step("sra", 1'b1, SRA, 1'b0, 1'b0);
    step("stl1", 1'b1, BEQ, 1'b1, 1'b0);
    step("stl2", 1'b1, BEQ, 1'b1, 1'b0);
    step("stl3", 1'b1, BEQ, 1'b1, 1'b0);
    step("beq", 1'b1, BEQ, 1'b0, 1'b0);
    step("flst", 1'b1, ADDI, 1'b1, 1'b1);
    step("fl", 1'b1, ADDI, 1'b0, 1'b1);

    step("lu.lw", 1'b1, LW, 1'b0, 1'b0);
    step("lu.st", 1'b1, ADD, 1'b1, 1'b0);
    step("lu.hz", 1'b1, ADD, 1'b0, 1'b0);
    step("lu.go", 1'b1, ADD, 1'b0, 1'b0);
    step("lw4", 1'b1, LW4, 1'b0, 1'b0);
    step("addi4", 1'b1, ADDI4, 1'b0, 1'b0);
    step("lw0", 1'b1, LW0, 1'b0, 1'b0);
    step("add00", 1'b1, ADD00, 1'b0, 1'b0);

    step("bad", 1'b1, BAD, 1'b0, 1'b0);
    idle("bad.off");
    step("mul", 1'b1, MUL, 1'b0, 1'b0);
    idle("mul.off");
    step("jal", 1'b1, JAL, 1'b0, 1'b0);
    step("jalr0", 1'b1, JALR0, 1'b0, 1'b0);
    step("lui", 1'b1, LUI, 1'b0, 1'b0);
    step("auipc", 1'b1, AUIPC, 1'b0, 1'b0);
    step("sw", 1'b1, SW, 1'b0, 1'b0);
    step("srai", 1'b1, SRAI, 1'b0, 1'b0);
    step("addin", 1'b1, ADDIN, 1'b0, 1'b0);

    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mrst.rdy", 192'(in_ready), 192'(0));
    check("mrst.valid", 192'(stage_valid), 192'(0));
    check("mrst.ctrl", 192'(stage_ctrl), 192'(0));
    check("mrst.ill", 192'(illegal), 192'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check("mrel.rdy0", 192'(in_ready), 192'(0));
    @(posedge clk);
    #1;
    check("mrel.rdy1", 192'(in_ready), 192'(1));
    check("mrel.valid", 192'(stage_valid), 192'(0));
    m_rdy = 1'b1;
    @(negedge clk);
    step("addi2", 1'b1, ADDI, 1'b0, 1'b0);
    idle("end1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
